// File: rtl/wb_port_sequencer_if.sv
// MEM/WB-to-register-file bus for wb_port_sequencer.
// master = pipeline side driving MEM/WB, slave = the sequencer.
interface wb_port_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic [DATA_W-1:0] memwbALUout;
  logic [DATA_W-1:0] memwbRD1;
  logic [DATA_W-1:0] memwbRD15;
  logic [REG_AW-1:0] memwbOP1;
  logic [REG_AW-1:0] memwbOP2;
  logic [2:0]        memwbregWrite;
  logic              memwbF;
  logic              memwbOF;
  logic              rfWrEn;
  logic [REG_AW-1:0] rfWrAddr;
  logic [DATA_W-1:0] rfWrData;
  logic              wbStall;
  logic              halted;
  logic              ovfExc;

  modport master (
    output memwbALUout, memwbRD1, memwbRD15, memwbOP1, memwbOP2,
           memwbregWrite, memwbF, memwbOF,
    input  rfWrEn, rfWrAddr, rfWrData, wbStall, halted, ovfExc
  );

  modport slave (
    input  memwbALUout, memwbRD1, memwbRD15, memwbOP1, memwbOP2,
           memwbregWrite, memwbF, memwbOF,
    output rfWrEn, rfWrAddr, rfWrData, wbStall, halted, ovfExc
  );
endinterface

// File: rtl/wb_port_sequencer.sv
// Serialises up to three register writes per MEM/WB instruction onto one write port.
// Optional WB_STATS_EN adds a saturating stallCount output.
module wb_port_sequencer #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 4,
  parameter int R15_ADDR = 15
) (
  input  logic                clk,
  input  logic                reset,
  wb_port_sequencer_if.slave  bus
`ifdef WB_STATS_EN
  ,
  output logic [15:0]         stallCount
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;

  localparam logic [REG_AW-1:0] R15 = REG_AW'(R15_ADDR);

  state_t            state_q, state_d;
  logic [2:0]        pend_q, pend_d;
  logic [DATA_W-1:0] alu_q, alu_d, rd1_q, rd1_d, rd15_q, rd15_d;
  logic [REG_AW-1:0] op1_q, op1_d, op2_q, op2_d;
  logic              f_q, f_d;
  logic              wr_en_q, wr_en_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              stall_q, stall_d;
  logic              halted_q, halted_d;
  logic              ovf_q, ovf_d;

  logic [2:0]        src_mask, low_bit, rem_mask;
  logic [DATA_W-1:0] cur_alu, cur_rd1, cur_rd15;
  logic [REG_AW-1:0] cur_op1, cur_op2;

  // In IDLE the write is picked straight from the inputs so it issues on the accept edge.
  always_comb begin
    if (state_q == IDLE) begin
      src_mask = bus.memwbregWrite;
      cur_alu  = bus.memwbALUout;
      cur_rd1  = bus.memwbRD1;
      cur_rd15 = bus.memwbRD15;
      cur_op1  = bus.memwbOP1;
      cur_op2  = bus.memwbOP2;
    end else begin
      src_mask = pend_q;
      cur_alu  = alu_q;
      cur_rd1  = rd1_q;
      cur_rd15 = rd15_q;
      cur_op1  = op1_q;
      cur_op2  = op2_q;
    end
    low_bit  = src_mask & (~src_mask + 3'd1);
    rem_mask = src_mask & ~low_bit;
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    alu_d     = alu_q;
    rd1_d     = rd1_q;
    rd15_d    = rd15_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    f_d       = f_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    stall_d   = 1'b0;
    halted_d  = halted_q;
    ovf_d     = 1'b0;

    unique case (low_bit)
      3'b001:  begin wr_addr_d = cur_op1; wr_data_d = cur_alu;  end
      3'b010:  begin wr_addr_d = cur_op2; wr_data_d = cur_rd1;  end
      3'b100:  begin wr_addr_d = R15;     wr_data_d = cur_rd15; end
      default: begin wr_addr_d = '0;      wr_data_d = '0;       end
    endcase

    unique case (state_q)
      IDLE: begin
        ovf_d = bus.memwbOF;
        if (bus.memwbOF || bus.memwbregWrite == 3'b000) begin
          wr_addr_d = '0;
          wr_data_d = '0;
          pend_d    = 3'b000;
          if (bus.memwbF) begin
            state_d  = HALT;
            halted_d = 1'b1;
            stall_d  = 1'b1;
          end
        end else begin
          wr_en_d = 1'b1;
          pend_d  = rem_mask;
          alu_d   = bus.memwbALUout;
          rd1_d   = bus.memwbRD1;
          rd15_d  = bus.memwbRD15;
          op1_d   = bus.memwbOP1;
          op2_d   = bus.memwbOP2;
          f_d     = bus.memwbF;
          if (rem_mask != 3'b000) begin
            state_d = ISSUE;
            stall_d = 1'b1;
          end else if (bus.memwbF) begin
            state_d = HALT;
          end
        end
      end
      ISSUE: begin
        wr_en_d = 1'b1;
        pend_d  = rem_mask;
        stall_d = (rem_mask != 3'b000);
        if (rem_mask == 3'b000) state_d = f_q ? HALT : IDLE;
      end
      HALT: begin
        wr_addr_d = '0;
        wr_data_d = '0;
        pend_d    = 3'b000;
        halted_d  = 1'b1;
        stall_d   = 1'b1;
      end
      default: begin
        state_d   = IDLE;
        wr_addr_d = '0;
        wr_data_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      alu_q     <= '0;
      rd1_q     <= '0;
      rd15_q    <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      f_q       <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      stall_q   <= 1'b0;
      halted_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      alu_q     <= alu_d;
      rd1_q     <= rd1_d;
      rd15_q    <= rd15_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      f_q       <= f_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      stall_q   <= stall_d;
      halted_q  <= halted_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.rfWrEn   = wr_en_q;
  assign bus.rfWrAddr = wr_addr_q;
  assign bus.rfWrData = wr_data_q;
  assign bus.wbStall  = stall_q;
  assign bus.halted   = halted_q;
  assign bus.ovfExc   = ovf_q;

`ifdef WB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Halt also raises wbStall, but those cycles are not write-back stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_q && !halted_q && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_sequencer.sv
// Self-checking bench for wb_port_sequencer: directed scenarios plus a randomized
// run against a queue-based model of the per-cycle write-back output stream.
module tb_wb_port_sequencer;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  wb_port_sequencer_if #(.DATA_W(16), .REG_AW(4)) bus ();

`ifdef WB_STATS_EN
  logic [15:0] stallCount;
`endif

  wb_port_sequencer #(.DATA_W(16), .REG_AW(4), .R15_ADDR(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave)
`ifdef WB_STATS_EN
    ,
    .stallCount (stallCount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output record layout: {rfWrEn, rfWrAddr[3:0], rfWrData[15:0], wbStall, halted, ovfExc}
  function automatic logic [23:0] outs();
    return {bus.rfWrEn, bus.rfWrAddr, bus.rfWrData, bus.wbStall, bus.halted, bus.ovfExc};
  endfunction

  function automatic logic [23:0] rec(input logic en, input logic [3:0] a, input logic [15:0] d,
                                      input logic st, input logic h, input logic o);
    return {en, a, d, st, h, o};
  endfunction

  task automatic drive(input logic [2:0] m, input logic [3:0] o1, input logic [3:0] o2,
                       input logic [15:0] a, input logic [15:0] r1, input logic [15:0] r15,
                       input logic f, input logic of);
    bus.memwbregWrite = m;
    bus.memwbOP1      = o1;
    bus.memwbOP2      = o2;
    bus.memwbALUout   = a;
    bus.memwbRD1      = r1;
    bus.memwbRD15     = r15;
    bus.memwbF        = f;
    bus.memwbOF       = of;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(3'b000, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(3'b111, 4'd5, 4'd6, 16'h1234, 16'h5678, 16'h9ABC, 1'b1, 1'b0);
    tick();
    tests_run++;
    if (outs() !== 24'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", outs(), 24'd0);
    end
`ifdef WB_STATS_EN
    tests_run++;
    if (stallCount !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_stallcount: got %0d expected 0", stallCount);
    end
`endif
    reset = 1'b1;
  endtask

  task automatic test_single_write();
    logic [23:0] e;
    do_reset();
    drive(3'b001, 4'd3, 4'd9, 16'hA0A0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    tick();
    e = rec(1'b1, 4'd3, 16'hA0A0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (outs() !== e) begin
      tests_failed++;
      $display("[TB] FAIL single_write: got %h expected %h", outs(), e);
    end
    drive(3'b000, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (outs() !== 24'd0) begin
      tests_failed++;
      $display("[TB] FAIL single_then_bubble: got %h expected %h", outs(), 24'd0);
    end
  endtask

  task automatic test_triple_write();
    logic [23:0] e [4];
    do_reset();
    e[0] = rec(1'b1, 4'd1,  16'h1BEA, 1'b1, 1'b0, 1'b0);
    e[1] = rec(1'b1, 4'd2,  16'h0BEA, 1'b1, 1'b0, 1'b0);
    e[2] = rec(1'b1, 4'hF,  16'h0098, 1'b0, 1'b0, 1'b0);
    e[3] = rec(1'b1, 4'd1,  16'h1BEA, 1'b1, 1'b0, 1'b0);
    drive(3'b111, 4'd1, 4'd2, 16'h1BEA, 16'h0BEA, 16'h0098, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (outs() !== e[i]) begin
        tests_failed++;
        $display("[TB] FAIL triple_cycle%0d: got %h expected %h", i, outs(), e[i]);
      end
`ifdef WB_STATS_EN
      if (i == 2) begin
        tests_run++;
        if (stallCount !== 16'd2) begin
          tests_failed++;
          $display("[TB] FAIL triple_stallcount: got %0d expected 2", stallCount);
        end
      end
`endif
    end
  endtask

  task automatic test_overflow();
    logic [23:0] e;
    do_reset();
    drive(3'b101, 4'd4, 4'd5, 16'hDEAD, 16'hBEEF, 16'hCAFE, 1'b0, 1'b1);
    tick();
    e = rec(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (outs() !== e) begin
      tests_failed++;
      $display("[TB] FAIL overflow_pulse: got %h expected %h", outs(), e);
    end
    drive(3'b000, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (outs() !== 24'd0) begin
      tests_failed++;
      $display("[TB] FAIL overflow_after: got %h expected %h", outs(), 24'd0);
    end
  endtask

  task automatic test_halt();
    logic [23:0] e;
    do_reset();
    drive(3'b010, 4'd2, 4'd7, 16'h0101, 16'hBEEF, 16'h0303, 1'b1, 1'b0);
    tick();
    e = rec(1'b1, 4'd7, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (outs() !== e) begin
      tests_failed++;
      $display("[TB] FAIL halt_write: got %h expected %h", outs(), e);
    end
    drive(3'b111, 4'd1, 4'd2, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b1);
    e = rec(1'b0, 4'd0, 16'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (outs() !== e) begin
        tests_failed++;
        $display("[TB] FAIL halt_sticky%0d: got %h expected %h", i, outs(), e);
      end
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tests_run++;
    if (outs() !== 24'd0) begin
      tests_failed++;
      $display("[TB] FAIL halt_reset: got %h expected %h", outs(), 24'd0);
    end
  endtask

  task automatic test_collision();
    logic [23:0] e;
    do_reset();
    drive(3'b101, 4'hF, 4'd3, 16'h1111, 16'h5555, 16'h2222, 1'b0, 1'b0);
    tick();
    e = rec(1'b1, 4'hF, 16'h1111, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (outs() !== e) begin
      tests_failed++;
      $display("[TB] FAIL collision_first: got %h expected %h", outs(), e);
    end
    drive(3'b000, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    tick();
    e = rec(1'b1, 4'hF, 16'h2222, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (outs() !== e) begin
      tests_failed++;
      $display("[TB] FAIL collision_second: got %h expected %h", outs(), e);
    end
  endtask

  task automatic test_reset_mid_sequence();
    logic [23:0] e;
    do_reset();
    drive(3'b111, 4'd1, 4'd2, 16'h1BEA, 16'h0BEA, 16'h0098, 1'b0, 1'b0);
    tick();
    tick();
    e = rec(1'b1, 4'd2, 16'h0BEA, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (outs() !== e) begin
      tests_failed++;
      $display("[TB] FAIL midreset_second: got %h expected %h", outs(), e);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive(3'b000, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (outs() !== 24'd0) begin
        tests_failed++;
        $display("[TB] FAIL midreset_dropped%0d: got %h expected %h", i, outs(), 24'd0);
      end
      tick();
    end
  endtask

  // Model: on acceptance, expand the instruction into the list of output records it
  // produces, one per cycle; the next instruction is accepted only once that list drains.
  task automatic test_random();
    logic [23:0] exp_q [$];
    logic [23:0] e, prev;
    logic        halted_m;
    logic [15:0] cnt_m;
    logic [2:0]  m;
    logic [3:0]  o1, o2;
    logic [15:0] a, r1, r15;
    logic        f, of;
    int          k;
    do_reset();
    halted_m = 1'b0;
    cnt_m    = 16'd0;
    prev     = 24'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      m   = 3'($urandom_range(0, 7));
      o1  = 4'($urandom_range(0, 15));
      o2  = 4'($urandom_range(0, 15));
      a   = 16'($urandom);
      r1  = 16'($urandom);
      r15 = 16'($urandom);
      f   = ($urandom_range(0, 11) == 0);
      of  = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 29) != 0);
      drive(m, o1, o2, a, r1, r15, f, of);

      if (!reset) begin
        exp_q.delete();
        halted_m = 1'b0;
        e = 24'd0;
        cnt_m = 16'd0;
      end else begin
        if (prev[2] && !prev[1] && cnt_m != 16'hFFFF) cnt_m++;
        if (exp_q.size() == 0 && !halted_m) begin
          if (of || m == 3'b000) begin
            exp_q.push_back(rec(1'b0, 4'd0, 16'd0, f, f, of));
          end else begin
            k = $countones(m);
            for (int b = 0; b < 3; b++) begin
              if (m[b]) begin
                k--;
                case (b)
                  0:       exp_q.push_back(rec(1'b1, o1,   a,   k > 0, 1'b0, 1'b0));
                  1:       exp_q.push_back(rec(1'b1, o2,   r1,  k > 0, 1'b0, 1'b0));
                  default: exp_q.push_back(rec(1'b1, 4'hF, r15, k > 0, 1'b0, 1'b0));
                endcase
              end
            end
          end
          halted_m = f;
        end
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else                   e = rec(1'b0, 4'd0, 16'd0, 1'b1, 1'b1, 1'b0);
      end
      prev = e;

      tick();
      tests_run++;
      if (outs() !== e) begin
        tests_failed++;
        $display("[TB] FAIL random_cycle%0d: got %h expected %h", cyc, outs(), e);
      end
`ifdef WB_STATS_EN
      tests_run++;
      if (stallCount !== cnt_m) begin
        tests_failed++;
        $display("[TB] FAIL random_stallcount%0d: got %0d expected %0d", cyc, stallCount, cnt_m);
      end
`endif
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    drive(3'b000, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    #2;
    test_reset();
    test_single_write();
    test_triple_write();
    test_overflow();
    test_halt();
    test_collision();
    test_reset_mid_sequence();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_port_sequencer.md
Name: wb_port_sequencer

Overview:
- Write-back controller between the MEM/WB pipeline register and the single-write-port register file.
- Each instruction in MEM/WB can request up to three register writes (primary result, secondary result, R15 result).
- The block issues those writes one per cycle and stalls the pipeline while writes are still outstanding.
- It also suppresses writes on overflow and latches the halt condition.

Parameters:
- DATA_W, 16: register/data width.
- REG_AW, 4: register address width.
- R15_ADDR, 15: address used for the R15 write.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- memwbALUout  input  DATA_W  primary result.
- memwbRD1  input  DATA_W  secondary result.
- memwbRD15  input  DATA_W  R15 result.
- memwbOP1  input  REG_AW  primary destination address.
- memwbOP2  input  REG_AW  secondary destination address.
- memwbregWrite  input  3  write request mask: [0] OP1<-ALUout, [1] OP2<-RD1, [2] R15<-RD15; 000 = bubble.
- memwbF  input  1  halt instruction.
- memwbOF  input  1  arithmetic overflow for this instruction.
- rfWrEn  output  1  register-file write enable.
- rfWrAddr  output  REG_AW  write address.
- rfWrData  output  DATA_W  write data.
- wbStall  output  1  freezes IF..MEM/WB while high.
- halted  output  1  sticky halt indicator.
- ovfExc  output  1  one-cycle overflow exception pulse.

Behaviour:
- Reset (reset==0 at an edge): all outputs go to 0, pending mask clears, state = IDLE.
- All outputs are registered.
- Accept edge: a rising edge with reset==1, wbStall==0 and halted==0. Only at an accept edge is the MEM/WB input sampled; at any other edge it is ignored.
- Accept with memwbOF==1:
  - No writes; mask discarded.
  - ovfExc=1 for exactly the following cycle.
  - wbStall stays 0.
  - memwbF still applies.
- Accept with mask==000 (bubble): rfWrEn=0 next cycle; memwbF still applies.
- Accept with a nonzero mask:
  - Capture the data, addresses and mask into holding registers.
  - Issue the lowest set bit at the same edge: rfWrEn=1 with its address/data for the next cycle.
  - Clear that bit from the pending mask.
- Following edges: issue the next lowest pending bit, one per cycle. Priority order is bit0, bit1, bit2.
- Latency: the first write is visible 1 cycle after accept. An instruction with k set bits occupies k cycles of rfWrEn.
- wbStall:
  - Set at any edge that issues a write while further bits remain pending.
  - Cleared at the edge that issues the last write.
  - Result: wbStall is high for k-1 cycles. A single write never stalls.
- FSM states:
  - IDLE (no pending): accept edge with more than one bit set goes to ISSUE.
  - ISSUE (pending nonzero): last bit issued goes to IDLE, or to HALT if the captured F was 1.
  - HALT: sticky until reset.
- From IDLE, an accept with F=1 and at most one write goes to HALT immediately after that write is issued.
- In HALT: halted=1, wbStall=1, rfWrEn=0 from the cycle after the final write.
- Address collisions are not merged. Example: OP1==R15_ADDR with bits 0 and 2 set gives two writes; R15 ends holding RD15 (last write wins). OP1==OP2 follows the same rule.
- reset==0 mid-sequence: pending writes are dropped. No partial-write recovery.

Optional Feature:
- Macro: WB_STATS_EN.
- Defined:
  - Adds output stallCount (16 bits): counts cycles with wbStall==1, excluding HALT.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset then single write: mask=001, OP1=3, ALUout=A0A0 -> next cycle rfWrEn=1, addr=3, data=A0A0; wbStall stays 0.
- Triple write: mask=111, OP1=1, OP2=2, ALUout=1BEA, RD1=0BEA, RD15=0098 -> three consecutive writes (1,1BEA), (2,0BEA), (F,0098).
  - wbStall high for exactly 2 cycles.
  - The next held instruction is accepted on the edge after the last write.
- Overflow: mask=101, OF=1 -> rfWrEn never asserted; ovfExc high exactly 1 cycle; wbStall 0.
- Halt: mask=010, F=1, OP2=7 -> one write (7, RD1), then halted=1, wbStall=1. Later inputs ignored until reset, which clears everything.
- Collision: mask=101, OP1=F, ALUout=1111, RD15=2222 -> writes (F,1111) then (F,2222).
- Reset asserted during the second cycle of a triple write -> outputs 0 next cycle; remaining writes never issued.
  - With WB_STATS_EN, stallCount reads 0 after reset and 2 after a triple write.
